// File: rtl/mat_result_unpacker_pkg.sv
// Shared matrix definitions: element width and dimension defaults, the
// unpacker FSM encoding and the element ordering used by the matrix
// multiplier when it packs a 2x2 result as {C00, C01, C10, C11}.
package mat_result_unpacker_pkg;

    // Default element width and matrix dimension.
    localparam int MAT_EW    = 16;
    localparam int MAT_N     = 2;
    localparam int MAT_ELEMS = MAT_N * MAT_N;

    // Unpacker FSM encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } unpack_state_e;

    // Element order inside a packed result.
    // Index bit 1 is the row and index bit 0 is the column.
    localparam logic [1:0] ELEM_C00  = 2'd0;
    localparam logic [1:0] ELEM_C01  = 2'd1;
    localparam logic [1:0] ELEM_C10  = 2'd2;
    localparam logic [1:0] ELEM_C11  = 2'd3;
    localparam logic [1:0] ELEM_LAST = ELEM_C11;

    // Slot number of an element inside the packed word. Slot 0 is the LSB
    // end, so C00 sits in the highest slot.
    function automatic int elem_slot(input logic [1:0] idx);
        return (MAT_ELEMS - 1) - int'(idx);
    endfunction

endpackage : mat_result_unpacker_pkg

// File: rtl/mat_result_unpacker.sv
// Streams a packed 2x2 matrix result out one element per beat in the order
// C00, C01, C10, C11, tagging each element with its row, column and a
// last-of-frame marker, and counts completed frames.
module mat_result_unpacker
    import mat_result_unpacker_pkg::*;
#(
    parameter int EW = MAT_EW,
    parameter int N  = MAT_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [N*N*EW-1:0] res_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW-1:0]     out_data,
    output logic              out_row,
    output logic              out_col,
    output logic              out_last,
    output logic [7:0]        frame_cnt
);

    // Only the 2x2 case is implemented; the packed width follows N so the
    // port shape stays tied to the matrix dimension.
    localparam int ELEMS = N * N;
    localparam int BW    = ELEMS * EW;

    // State registers and their next-state values.
    unpack_state_e state_q;
    unpack_state_e state_d;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic [BW-1:0] buf_q;
    logic [BW-1:0] buf_d;
    logic [7:0]    frame_cnt_q;
    logic [7:0]    frame_cnt_d;

    // Decoded handshake terms.
    logic          sending_s;
    logic          capture_s;
    logic          beat_s;
    logic          last_idx_s;
    logic [EW-1:0] elem_s;

    // Handshake decode from the registered state only, so the outputs never
    // depend combinationally on the inputs.
    always_comb begin
        sending_s  = (state_q == ST_SEND);
        last_idx_s = (idx_q == ELEM_LAST);
        capture_s  = 1'b0;
        beat_s     = 1'b0;
        if (sending_s) begin
            beat_s = out_ready;
        end else begin
            capture_s = res_valid;
        end
    end

    // Next-state logic: capture in IDLE, advance the element index on beats
    // in SEND, close the frame on the final beat.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    buf_d   = res_data;
                    idx_d   = ELEM_C00;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // New results arriving here are ignored: buf_d keeps buf_q.
                if (beat_s) begin
                    if (last_idx_s) begin
                        idx_d       = ELEM_C00;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = ELEM_C00;
            end
        endcase
    end

    // State register with asynchronous active-low reset; reset mid-frame
    // simply drops the frame without counting it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= ELEM_C00;
            buf_q       <= '0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // 4:1 element select on the index; elements pass through untouched.
    always_comb begin
        elem_s = '0;
        case (idx_q)
            ELEM_C00: elem_s = buf_q[elem_slot(ELEM_C00)*EW +: EW];
            ELEM_C01: elem_s = buf_q[elem_slot(ELEM_C01)*EW +: EW];
            ELEM_C10: elem_s = buf_q[elem_slot(ELEM_C10)*EW +: EW];
            ELEM_C11: elem_s = buf_q[elem_slot(ELEM_C11)*EW +: EW];
            default:  elem_s = '0;
        endcase
    end

    // Output drive: element fields are forced to zero while idle so the bus
    // is quiet between frames and matches the reset values.
    always_comb begin
        res_ready = ~sending_s;
        out_valid = sending_s;
        frame_cnt = frame_cnt_q;
        if (sending_s) begin
            out_data = elem_s;
            out_row  = idx_q[1];
            out_col  = idx_q[0];
            out_last = last_idx_s;
        end else begin
            out_data = '0;
            out_row  = 1'b0;
            out_col  = 1'b0;
            out_last = 1'b0;
        end
    end

endmodule : mat_result_unpacker

// File: tb/tb_mat_result_unpacker.sv
// Self-checking bench for mat_result_unpacker. A frame-level reference model
// (a busy flag, the four captured elements and a position counter) predicts
// every output; a scoreboard of accepted elements checks ordering and
// exactly-once delivery under random handshakes.
module tb_mat_result_unpacker;

    localparam int EW = 16;

    logic          clk;
    logic          reset;
    logic          res_valid;
    logic          res_ready;
    logic [63:0]   res_data;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_data;
    logic          out_row;
    logic          out_col;
    logic          out_last;
    logic [7:0]    frame_cnt;

    int total;
    int bad;

    // Reference model state.
    bit          m_busy;
    logic [15:0] m_frame [4];
    int          m_pos;
    logic [7:0]  m_cnt;
    logic [17:0] sb_q [$];   // {row, col, data} in expected delivery order

    mat_result_unpacker #(.EW(EW), .N(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [28:0] dut_bundle = {out_valid, out_data, out_row, out_col, out_last, res_ready, frame_cnt};

    function automatic logic [28:0] exp_bundle();
        logic [15:0] d;
        logic        r;
        logic        c;
        logic        l;
        d = m_busy ? m_frame[m_pos] : 16'h0000;
        r = m_busy && (m_pos >= 2);
        c = m_busy && (m_pos % 2 == 1);
        l = m_busy && (m_pos == 3);
        return {m_busy, d, r, c, l, !m_busy, m_cnt};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_pos  = 0;
        m_cnt  = 8'd0;
        sb_q.delete();
    endtask

    // One clock edge as seen by the model, using the inputs held across it.
    task automatic model_step();
        if (!m_busy) begin
            if (res_valid) begin
                for (int i = 0; i < 4; i++) begin
                    m_frame[i] = res_data[(3 - i) * 16 +: 16];
                    sb_q.push_back({(i >= 2) ? 1'b1 : 1'b0, (i % 2 == 1) ? 1'b1 : 1'b0, res_data[(3 - i) * 16 +: 16]});
                end
                m_pos  = 0;
                m_busy = 1'b1;
            end
        end else if (out_ready) begin
            if (m_pos == 3) begin
                m_busy = 1'b0;
                m_pos  = 0;
                m_cnt  = m_cnt + 8'd1;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        res_valid = 1'b0;
        res_data  = 64'h0;
        out_ready = 1'b0;
        reset     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        res_valid = 1'b0;
        res_data = 64'h0;
        out_ready = 1'b1;
        model_reset();
        #3;
        total++;
        if (dut_bundle !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", dut_bundle, {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
        end
        apply_reset();
        total++;
        if (res_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: res_ready=%b out_valid=%b want 1/0", res_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [1:0] rc;
        apply_reset();
        res_data  = 64'h0001_0002_0003_0004;
        res_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rc = i[1:0];
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'(i + 1) || {out_row, out_col} !== rc
                || out_last !== (i == 3)) begin
                bad++;
                $display("FAIL basic_elem%0d: v=%b d=%h rc=%b%b last=%b want 1 %h %b %b", i,
                         out_valid, out_data, out_row, out_col, out_last, 16'(i + 1), rc, (i == 3));
            end
            tick();
        end
        total++;
        if (frame_cnt !== 8'd1 || out_valid !== 1'b0 || res_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_end: frame_cnt=%0d v=%b rdy=%b want 1 0 1", frame_cnt, out_valid, res_ready);
        end
    endtask

    task automatic test_stall();
        res_data  = 64'h0001_0002_0003_0004;
        res_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();                      // C00 accepted, now at C01
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'h0002 || {out_row, out_col} !== 2'b01) begin
                bad++;
                $display("FAIL stall_hold%0d: v=%b d=%h rc=%b%b want 1 0002 01", k, out_valid, out_data, out_row, out_col);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            total++;
            if (out_data !== 16'(i + 1) || dut_bundle !== exp_bundle()) begin
                bad++;
                $display("FAIL stall_resume%0d: got %h want %h", i, dut_bundle, exp_bundle());
            end
            tick();
        end
        total++;
        if (frame_cnt !== 8'd2 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_end: frame_cnt=%0d v=%b want 2 0", frame_cnt, out_valid);
        end
    endtask

    task automatic test_ignored_input();
        logic [63:0] x;
        x = {$urandom, $urandom};
        res_data  = x;
        res_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        res_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_data !== x[(3 - i) * 16 +: 16] || res_ready !== 1'b0 || dut_bundle !== exp_bundle()) begin
                bad++;
                $display("FAIL ignored_elem%0d: d=%h rdy=%b want %h 0", i, out_data, res_ready, x[(3 - i) * 16 +: 16]);
            end
            tick();
        end
        total++;
        if (res_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ignored_idle: rdy=%b v=%b want 1 0", res_ready, out_valid);
        end
        tick();
        res_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'hFFFF || {out_row, out_col} !== 2'b00) begin
            bad++;
            $display("FAIL ignored_next: v=%b d=%h rc=%b%b want 1 ffff 00", out_valid, out_data, out_row, out_col);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] y;
        apply_reset();
        res_data  = {$urandom, $urandom};
        res_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        repeat (2) tick();
        total++;
        if ({out_row, out_col} !== 2'b10 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: rc=%b%b v=%b want 10 1", out_row, out_col, out_valid);
        end
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'd0 || out_data !== 16'h0000) begin
            bad++;
            $display("FAIL midrst_now: v=%b cnt=%0d d=%h want 0 0 0000", out_valid, frame_cnt, out_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        y = {$urandom, $urandom};
        res_data  = y;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        total++;
        if (out_data !== y[63:48] || {out_row, out_col} !== 2'b00 || frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL midrst_next: d=%h rc=%b%b cnt=%0d want %h 00 0", out_data, out_row, out_col, frame_cnt, y[63:48]);
        end
        repeat (4) tick();
    endtask

    task automatic test_wrap();
        int last_seen;
        int lasts;
        int cyc;
        apply_reset();
        res_valid = 1'b1;
        out_ready = 1'b1;
        last_seen = -1;
        lasts     = 0;
        for (cyc = 0; cyc < 1280; cyc++) begin
            res_data = {$urandom, $urandom};
            total++;
            if (dut_bundle !== exp_bundle()) begin
                bad++;
                $display("FAIL wrap_cyc%0d: got %h want %h", cyc, dut_bundle, exp_bundle());
            end
            if (out_last === 1'b1) begin
                if (last_seen >= 0) begin
                    total++;
                    if (cyc - last_seen !== 5) begin
                        bad++;
                        $display("FAIL wrap_period: got %0d want 5", cyc - last_seen);
                    end
                end
                last_seen = cyc;
                lasts++;
            end
            tick();
        end
        res_valid = 1'b0;
        total++;
        if (lasts !== 256 || frame_cnt !== 8'd0) begin
            bad++;
            $display("FAIL wrap_end: frames=%0d cnt=%0d want 256 0", lasts, frame_cnt);
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [17:0] e;
        apply_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            res_valid = ($urandom_range(0, 9) < 6);
            res_data  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            total++;
            if (dut_bundle !== exp_bundle()) begin
                bad++;
                $display("FAIL rand_cyc%0d: got %h want %h", cyc, dut_bundle, exp_bundle());
            end
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_sb_empty: beat at cycle %0d with nothing expected", cyc);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_row, out_col, out_data} !== e) begin
                        bad++;
                        $display("FAIL rand_sb%0d: got %h want %h", cyc, {out_row, out_col, out_data}, e);
                    end
                end
            end
            tick();
        end
        total++;
        if (sb_q.size() !== (m_busy ? 4 - m_pos : 0)) begin
            bad++;
            $display("FAIL rand_left: pending=%0d want %0d", sb_q.size(), (m_busy ? 4 - m_pos : 0));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_stall();
        test_ignored_input();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mat_result_unpacker

// File: doc/mat_result_unpacker.md
MAT_RESULT_UNPACKER -- requirements
Module: mat_result_unpacker

Interface
REQ-001 The module SHALL have parameter EW, default 16, giving the width of one result-matrix element.
REQ-002 The module SHALL have parameter N, default 2, giving the matrix dimension; only N=2 is supported.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port res_valid, input, 1 bit: the packed result on res_data is valid.
REQ-006 The module SHALL have port res_ready, output, 1 bit: the block can accept a packed result.
REQ-007 The module SHALL have port res_data, input, 4*EW bits: packed result {C00,C01,C10,C11}, with C00 in the MSBs.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_data, out_row, out_col and out_last are valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the current element.
REQ-010 The module SHALL have port out_data, output, EW bits: the current element.
REQ-011 The module SHALL have port out_row, output, 1 bit: row index of the current element.
REQ-012 The module SHALL have port out_col, output, 1 bit: column index of the current element.
REQ-013 The module SHALL have port out_last, output, 1 bit: high on the fourth (final) element of a frame.
REQ-014 The module SHALL have port frame_cnt, output, 8 bits: count of completed frames, wrapping modulo 256.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and SEND, with an element index idx of 2 bits.
REQ-016 In IDLE, res_ready SHALL be 1 and out_valid SHALL be 0; in SEND, res_ready SHALL be 0.
REQ-017 A capture SHALL occur on a rising edge where res_valid=1 and res_ready=1; it loads res_data into a 4*EW-bit buffer, sets idx=0 and moves the FSM to SEND.
REQ-018 Capture latency SHALL be one cycle: out_valid=1 with C00 on out_data in the cycle after the capture edge.
REQ-019 In SEND, out_valid SHALL be 1, out_data SHALL be buffer element idx in the order C00, C01, C10, C11, out_row SHALL equal idx[1], and out_col SHALL equal idx[0].
REQ-020 out_last SHALL be 1 exactly when out_valid=1 and idx=3.
REQ-021 A beat SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-022 On a beat with idx<3, idx SHALL increment by one.
REQ-023 On a beat with idx=3, the FSM SHALL return to IDLE and frame_cnt SHALL increment, wrapping from 255 to 0.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_row, out_col, out_last and idx SHALL hold stable, with no limit on stall duration.
REQ-025 Throughput SHALL be 5 cycles per frame minimum: 4 beats plus 1 IDLE cycle; res_ready SHALL NOT be asserted during SEND.
REQ-026 res_valid asserted during SEND SHALL be ignored, and the buffer SHALL NOT change.
REQ-027 out_ready asserted in IDLE SHALL have no effect.
REQ-028 Elements SHALL pass through unmodified: no sign extension, truncation or arithmetic.

Reset
REQ-029 Asserting reset (low) SHALL asynchronously force: state=IDLE, idx=0, buffer=0, frame_cnt=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, res_ready=1 (after release).
REQ-030 Reset asserted mid-frame SHALL abandon the frame without completing it and SHALL NOT increment frame_cnt.
REQ-031 Reset release SHALL be synchronous to clk externally; the first capture is possible on the first edge after release.

Structure
REQ-032 A shared matrix package SHALL hold the EW and N defaults, the FSM state encoding (IDLE=0, SEND=1) and the element-order constants shared with the matrix multiplier.
REQ-033 The design SHALL be a single module with no sub-modules; the element select SHALL be a 4:1 mux on idx.

Verification
REQ-034 Scenario basic: reset, then res_data=0x0001_0002_0003_0004 with res_valid for 1 cycle and out_ready=1 -> out_data 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles, row/col 00, 01, 10, 11, out_last only on 0x0004, frame_cnt=1.
REQ-035 Scenario stall: out_ready=0 for 3 cycles at idx=1 -> out_data holds 0x0002 with out_valid=1 throughout, then the sequence resumes without loss or duplication.
REQ-036 Scenario ignored input: res_valid=1 with 0xFFFF_FFFF_FFFF_FFFF during SEND -> the current frame is unchanged and the new value is accepted only in the next IDLE cycle.
REQ-037 Scenario reset mid-frame: reset low at idx=2 -> out_valid=0 immediately, frame_cnt unchanged, and the next frame starts at C00.
REQ-038 Scenario wrap: 256 back-to-back frames with res_valid held high -> frame_cnt returns to 0, and the frame period is exactly 5 cycles with out_ready=1.
REQ-039 Scenario random: random res_valid/out_ready over 10k cycles against a scoreboard -> every element appears in order, exactly once.
